coeff_bank_lut: RTL and testbench
=================================

// Module: coeff_bank_lut
// PURPOSE
//  Multi-bank, runtime-loadable coefficient lookup table for the speech front end. It replaces the
//  fixed single-table lookups with BANKS independent tables. Each table is addressed by quantised
//  feature codes. A single read returns one word; a burst read streams consecutive words.
//  The block sits between the feature quantiser (read side) and the host or config loader (write side).
// PARAMETERS
//  DATA_W    8   coefficient word width
//  ADDR_W    8   table address width; DEPTH = 2**ADDR_W entries per bank
//  BANKS     2   number of independent tables (>=2); BSEL_W = $clog2(BANKS)
//  INIT_VAL  2   default contents of entries 1..DEPTH-1 after reset
//  ZERO_VAL  0   fixed contents of entry 0 of every bank (silence code); not writable
//  LEN_W     4   burst length field width
// PORTS
//  CS        in   1       clock, rising edge
//  cen       in   1       reset, asynchronous, active-high
//  wr_en     in   1       write strobe, sampled at CS rising edge
//  wr_bank   in   BSEL_W  bank selected for the write
//  wr_addr   in   ADDR_W  write address
//  wr_data   in   DATA_W  write data
//  rd_req    in   1       read request; accepted only when rd_busy=0
//  rd_bank   in   BSEL_W  bank for the read, latched on accept
//  rd_addr   in   ADDR_W  start address, latched on accept
//  rd_len    in   LEN_W   number of words to read; 0 is treated as 1
//  rd_busy   out  1       high while a burst is in progress (state BURST)
//  rd_valid  out  1       rd_data is valid this cycle
//  rd_data   out  DATA_W  read data
//  rd_last   out  1       high together with rd_valid on the final word of a request
//  wr_err    out  1       one-cycle pulse: the write was rejected (address 0 or bank >= BANKS)
// BEHAVIOUR
//  Reset (cen=1, async): all outputs 0, FSM = IDLE.
//   Entries 1..DEPTH-1 of every bank return to INIT_VAL. Entry 0 is ZERO_VAL.
//   Reset mid-burst aborts the burst at once and produces no rd_last.
//  Storage: flop array BANKS x DEPTH x DATA_W. Entry 0 is hardwired to ZERO_VAL, not stored.
//  Write: at the CS edge with wr_en=1, if wr_addr!=0 and wr_bank<BANKS, mem[wr_bank][wr_addr] <= wr_data.
//   Otherwise the memory is unchanged and wr_err=1 on the next cycle.
//  FSM states: IDLE, BURST.
//   IDLE: rd_req=1 latches bank, addr and cnt = max(rd_len,1).
//    The first word is presented the next cycle (latency 1), with rd_valid=1.
//    If cnt=1, rd_last=1 and the FSM stays in IDLE. Otherwise it goes to BURST with rd_busy=1.
//   BURST: one word per cycle. Address increments modulo DEPTH (DEPTH-1 wraps to 0, which reads ZERO_VAL).
//    The final word asserts rd_last, then the FSM returns to IDLE and rd_busy drops in the same cycle.
//    rd_req is ignored while rd_busy=1.
//  Back-to-back: rd_req in the rd_last cycle is accepted. Its first word follows with no gap.
//  Bank >= BANKS on a read: every word reads ZERO_VAL. No error flag.
//  Read/write collision (same bank and address, same edge): the read returns OLD data (read-before-write).
//   The written value is visible from the next read onward.
//  Outputs are registered. Between valid words rd_data holds its last value and rd_valid=0.
// TESTING
//  1. After reset, read bank0 addr0 and addr5 (len 1) -> rd_data 0x00, then 0x02, each with rd_valid and rd_last.
//  2. Write bank1 addr 0x10 = 0xA5, then read bank1 0x10 -> 0xA5; bank0 0x10 still -> 0x02.
//  3. Write addr 0 with 0x55 -> wr_err pulse, one cycle; a read of addr 0 -> 0x00.
//  4. Burst: bank0, addr 0xFE, len 4 -> 4 words from addrs 0xFE, 0xFF, 0x00, 0x01 = 02, 02, 00, 02.
//     rd_last on the 4th word; rd_busy high for exactly 3 cycles.
//  5. Write 0x77 to bank0 0x20 on the same edge as a read of bank0 0x20 -> read returns 0x02; the next read returns 0x77.
//  6. Assert cen in the middle of a len 8 burst -> outputs 0 at once, no rd_last.
//     After release, bank1 0x10 reads back 0x02 (the loaded value is cleared).

Source files
------------

// File: rtl/coeff_bank_lut.sv
// Multi-bank, runtime-loadable coefficient lookup table with single and burst reads.
// Entry 0 of every bank is a fixed silence code; all other entries reload to INIT_VAL on reset.
module coeff_bank_lut #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int BANKS    = 2,
  parameter int INIT_VAL = 2,
  parameter int ZERO_VAL = 0,
  parameter int LEN_W    = 4,
  localparam int BSEL_W  = $clog2(BANKS)
) (
  input  logic              CS,
  input  logic              cen,
  input  logic              wr_en,
  input  logic [BSEL_W-1:0] wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [BSEL_W-1:0] rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              wr_err
);

  // state | meaning
  // IDLE  | no burst in flight; a request is accepted and its first word issued
  // BURST | streaming the remaining words of an accepted request
  typedef enum logic {IDLE, BURST} state_t;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [DATA_W-1:0] INIT_W = DATA_W'(INIT_VAL);
  localparam logic [DATA_W-1:0] ZERO_W = DATA_W'(ZERO_VAL);
  localparam logic [BSEL_W:0]   BANKS_W = (BSEL_W+1)'(BANKS);

  // Entry 0 is never stored; it is substituted on read.
  logic [DATA_W-1:0] mem_q [BANKS][1:DEPTH-1];
  logic [DATA_W-1:0] mem_d [BANKS][1:DEPTH-1];

  state_t            state_q, state_d;
  logic [BSEL_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              wr_err_q, wr_err_d;

  logic              wr_ok;
  logic              emit;
  logic [BSEL_W-1:0] sel_bank;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_word;

  assign wr_ok = wr_en && (wr_addr != '0) && ({1'b0, wr_bank} < BANKS_W);

  always_comb begin
    mem_d = mem_q;
    if (wr_ok) mem_d[wr_bank][wr_addr] = wr_data;
  end

  assign wr_err_d = wr_en && !wr_ok;

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    emit     = 1'b0;
    sel_bank = bank_q;
    sel_addr = addr_q;
    rd_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          emit     = 1'b1;
          sel_bank = rd_bank;
          sel_addr = rd_addr;
          bank_d   = rd_bank;
          addr_d   = rd_addr + ADDR_W'(1);
          // cnt holds words still to stream after this one; length 0 behaves as 1
          cnt_d    = (rd_len == '0) ? '0 : rd_len - LEN_W'(1);
          if (rd_len <= LEN_W'(1)) rd_last_d = 1'b1;
          else                     state_d   = BURST;
        end
      end
      BURST: begin
        emit   = 1'b1;
        addr_d = addr_q + ADDR_W'(1);
        cnt_d  = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1)) begin
          rd_last_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reads use the pre-write array contents, giving read-before-write on collisions.
  always_comb begin
    sel_word = ZERO_W;
    if ((sel_addr != '0) && ({1'b0, sel_bank} < BANKS_W))
      sel_word = mem_q[sel_bank][sel_addr];
  end

  assign rd_valid_d = emit;
  assign rd_data_d  = emit ? sel_word : rd_data_q;

  always_ff @(posedge CS or posedge cen) begin
    if (cen) begin
      for (int b = 0; b < BANKS; b++)
        for (int a = 1; a < DEPTH; a++)
          mem_q[b][a] <= INIT_W;
      state_q    <= IDLE;
      bank_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      state_q    <= state_d;
      bank_q     <= bank_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign rd_busy  = (state_q == BURST);
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_data  = rd_data_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_coeff_bank_lut.sv
// Self-checking bench for coeff_bank_lut: a reference table model feeds an expected-word
// queue that a monitor drains whenever the DUT presents rd_valid.
module tb_coeff_bank_lut;

  logic       CS = 1'b0;
  logic       cen = 1'b1;
  logic       wr_en = 1'b0;
  logic [0:0] wr_bank = '0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_req = 1'b0;
  logic [0:0] rd_bank = '0;
  logic [7:0] rd_addr = '0;
  logic [3:0] rd_len = '0;
  logic       rd_busy, rd_valid, rd_last, wr_err;
  logic [7:0] rd_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [8:0] exp_q[$];
  logic [7:0] model [2][256];

  coeff_bank_lut dut (
    .CS(CS), .cen(cen),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_busy(rd_busy), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .wr_err(wr_err)
  );

  always #5 CS = ~CS;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every presented word must match the head of the expected queue.
  always @(posedge CS) begin
    logic [8:0] e;
    #1;
    if (rd_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: got data=%02h last=%0b, expected no word", rd_data, rd_last);
      end else begin
        e = exp_q.pop_front();
        if ({rd_last, rd_data} !== e) begin
          n_fail++;
          $display("FAIL rd_word: got data=%02h last=%0b, expected data=%02h last=%0b",
                   rd_data, rd_last, e[7:0], e[8]);
        end
      end
    end
  end

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 256; a++)
        model[b][a] = 8'h02;
  endtask

  function automatic logic [7:0] model_rd(input logic [0:0] b, input logic [7:0] a);
    return (a == 8'h00) ? 8'h00 : model[b][a];
  endfunction

  task automatic push_burst(input logic [0:0] b, input logic [7:0] a, input int len);
    int n;
    logic [7:0] ad;
    n = (len == 0) ? 1 : len;
    ad = a;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), model_rd(b, ad)});
      ad = ad + 8'h01;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) @(negedge CS);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d words still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic issue_read(input logic [0:0] b, input logic [7:0] a, input logic [3:0] len);
    @(negedge CS);
    rd_req = 1'b1; rd_bank = b; rd_addr = a; rd_len = len;
    push_burst(b, a, int'(len));
    @(negedge CS);
    rd_req = 1'b0;
  endtask

  task automatic do_write(input logic [0:0] b, input logic [7:0] a, input logic [7:0] d,
                          input logic exp_err);
    @(negedge CS);
    wr_en = 1'b1; wr_bank = b; wr_addr = a; wr_data = d;
    @(negedge CS);
    wr_en = 1'b0;
    if (!exp_err) model[b][a] = d;
    n_checks++;
    if (wr_err !== exp_err) begin
      n_fail++;
      $display("FAIL wr_err_pulse: got %0b, expected %0b (bank %0d addr %02h)", wr_err, exp_err, b, a);
    end
    @(negedge CS);
    n_checks++;
    if (wr_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_err_width: got %0b one cycle later, expected 0", wr_err);
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge CS);
    n_checks++;
    if ({rd_busy, rd_valid, rd_last, wr_err, rd_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b valid=%0b last=%0b err=%0b data=%02h, expected all 0",
               rd_busy, rd_valid, rd_last, wr_err, rd_data);
    end
    cen = 1'b0;
  endtask

  task automatic test_single_read();
    issue_read(1'b0, 8'h00, 4'd1);
    issue_read(1'b0, 8'h05, 4'd1);
    issue_read(1'b1, 8'h33, 4'd0);
    wait_drain("single_read");
  endtask

  task automatic test_write_read();
    do_write(1'b1, 8'h10, 8'hA5, 1'b0);
    issue_read(1'b1, 8'h10, 4'd1);
    issue_read(1'b0, 8'h10, 4'd1);
    wait_drain("write_read");
  endtask

  task automatic test_zero_write();
    do_write(1'b0, 8'h00, 8'h55, 1'b1);
    issue_read(1'b0, 8'h00, 4'd1);
    wait_drain("zero_write");
  endtask

  task automatic test_burst_wrap();
    int busy_cnt;
    busy_cnt = 0;
    @(negedge CS);
    rd_req = 1'b1; rd_bank = 1'b0; rd_addr = 8'hFE; rd_len = 4'd4;
    push_burst(1'b0, 8'hFE, 4);
    for (int i = 0; i < 7; i++) begin
      @(posedge CS);
      #1;
      rd_req = 1'b0;
      if (rd_busy === 1'b1) busy_cnt++;
    end
    n_checks++;
    if (busy_cnt != 3) begin
      n_fail++;
      $display("FAIL burst_busy_cycles: got %0d, expected 3", busy_cnt);
    end
    wait_drain("burst_wrap");
  endtask

  task automatic test_collision();
    @(negedge CS);
    wr_en = 1'b1; wr_bank = 1'b0; wr_addr = 8'h20; wr_data = 8'h77;
    rd_req = 1'b1; rd_bank = 1'b0; rd_addr = 8'h20; rd_len = 4'd1;
    push_burst(1'b0, 8'h20, 1);
    model[0][8'h20] = 8'h77;
    @(negedge CS);
    wr_en = 1'b0; rd_req = 1'b0;
    issue_read(1'b0, 8'h20, 4'd1);
    wait_drain("collision");
  endtask

  task automatic test_back_to_back();
    int valid_cnt;
    valid_cnt = 0;
    do_write(1'b0, 8'h40, 8'h11, 1'b0);
    do_write(1'b0, 8'h41, 8'h12, 1'b0);
    do_write(1'b0, 8'h50, 8'h13, 1'b0);
    do_write(1'b0, 8'h60, 8'h14, 1'b0);
    @(negedge CS);
    rd_req = 1'b1; rd_bank = 1'b0; rd_addr = 8'h40; rd_len = 4'd2;
    push_burst(1'b0, 8'h40, 2);
    push_burst(1'b0, 8'h60, 1);
    @(posedge CS); #1;
    if (rd_valid === 1'b1) valid_cnt++;
    rd_addr = 8'h50; rd_len = 4'd1;
    @(posedge CS); #1;
    if (rd_valid === 1'b1) valid_cnt++;
    rd_addr = 8'h60; rd_len = 4'd1;
    @(posedge CS); #1;
    if (rd_valid === 1'b1) valid_cnt++;
    rd_req = 1'b0;
    n_checks++;
    if (valid_cnt != 3) begin
      n_fail++;
      $display("FAIL b2b_gapless: got %0d valid cycles, expected 3", valid_cnt);
    end
    wait_drain("back_to_back");
  endtask

  task automatic test_reset_mid_burst();
    @(negedge CS);
    rd_req = 1'b1; rd_bank = 1'b0; rd_addr = 8'h40; rd_len = 4'd8;
    push_burst(1'b0, 8'h40, 8);
    @(posedge CS); #1;
    rd_req = 1'b0;
    @(posedge CS);
    @(posedge CS); #3;
    cen = 1'b1;
    #1;
    n_checks++;
    if ({rd_busy, rd_valid, rd_last, wr_err, rd_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%0b valid=%0b last=%0b data=%02h, expected all 0",
               rd_busy, rd_valid, rd_last, rd_data);
    end
    exp_q.delete();
    model_reset();
    @(negedge CS);
    @(negedge CS);
    n_checks++;
    if ({rd_valid, rd_last} !== 2'b00) begin
      n_fail++;
      $display("FAIL abort_no_last: got valid=%0b last=%0b, expected 0 0", rd_valid, rd_last);
    end
    cen = 1'b0;
    issue_read(1'b1, 8'h10, 4'd1);
    issue_read(1'b0, 8'h40, 4'd1);
    wait_drain("reset_mid_burst");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_read();
    test_zero_write();
    test_burst_wrap();
    test_collision();
    test_back_to_back();
    test_reset_mid_burst();
    repeat (2) @(negedge CS);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
